// File: rtl/phys_free_list_pkg.sv
// Shared physical-register constants and index type for the rename,
// dispatch and complete stages and the free pool.
package phys_free_list_pkg;

    localparam int NUM_PREG = 64;
    localparam int NUM_ARCH = 32;
    localparam int PREG_W   = $clog2(NUM_PREG);

    typedef logic [PREG_W-1:0] preg_t;

endpackage

// File: rtl/phys_free_list_if.sv
// Rename/retire side of the physical-register free pool. The master is the
// pipeline (rename requests plus retire frees); the slave is the pool.
interface phys_free_list_if
    import phys_free_list_pkg::*;
#(
    parameter int IDX_W = phys_free_list_pkg::PREG_W
);

    logic             alloc_req_1;
    logic             alloc_req_2;
    logic             alloc_grant_1;
    logic             alloc_grant_2;
    logic [IDX_W-1:0] alloc_preg_1;
    logic [IDX_W-1:0] alloc_preg_2;
    logic             retire_flag_1;
    logic [IDX_W-1:0] fp_ind_1;
    logic             retire_flag_2;
    logic [IDX_W-1:0] fp_ind_2;
    logic [IDX_W:0]   free_count;
    logic             empty;
    logic             free_err;

    modport master (
        output alloc_req_1, alloc_req_2,
        output retire_flag_1, fp_ind_1, retire_flag_2, fp_ind_2,
        input  alloc_grant_1, alloc_grant_2, alloc_preg_1, alloc_preg_2,
        input  free_count, empty, free_err
    );

    modport slave (
        input  alloc_req_1, alloc_req_2,
        input  retire_flag_1, fp_ind_1, retire_flag_2, fp_ind_2,
        output alloc_grant_1, alloc_grant_2, alloc_preg_1, alloc_preg_2,
        output free_count, empty, free_err
    );

endinterface

// File: rtl/phys_free_list.sv
// Physical-register free pool: circular buffer of free indices plus an in-pool
// bitmap, two allocations and two frees per cycle.
module phys_free_list
    import phys_free_list_pkg::*;
#(
    parameter int NUM_PREG = phys_free_list_pkg::NUM_PREG,
    parameter int NUM_ARCH = phys_free_list_pkg::NUM_ARCH,
    parameter int PREG_W   = phys_free_list_pkg::PREG_W
) (
    input  logic            clk,
    input  logic            rst,
    phys_free_list_if.slave pif
);

    typedef logic [PREG_W-1:0] idx_t;
    typedef logic [PREG_W:0]   cnt_t;

    idx_t                entries_r [NUM_PREG];
    idx_t                head_r;
    idx_t                tail_r;
    cnt_t                count_r;
    logic [NUM_PREG-1:0] in_pool_r;
    logic                empty_r;
    logic                free_err_r;

    logic                grant_1_s;
    logic                grant_2_s;
    idx_t                preg_1_s;
    idx_t                preg_2_s;
    logic                acc_1_s;
    logic                acc_2_s;
    logic                drop_s;
    idx_t                tail_2_s;
    cnt_t                count_next_s;
    logic [NUM_PREG-1:0] pool_next_s;

    // Grants, allocated indices and free acceptance from registered state only.
    always_comb begin
        grant_1_s = pif.alloc_req_1 && (count_r != {(PREG_W+1){1'b0}});
        if (pif.alloc_req_1) begin
            grant_2_s = pif.alloc_req_2 && (count_r >= cnt_t'(2));
        end else begin
            grant_2_s = pif.alloc_req_2 && (count_r != {(PREG_W+1){1'b0}});
        end
        preg_1_s = entries_r[head_r];
        preg_2_s = entries_r[head_r + idx_t'(grant_1_s)];

        // p0 backs x0: freeing it is neither accepted nor an error.
        acc_1_s = pif.retire_flag_1 && (pif.fp_ind_1 != {PREG_W{1'b0}})
                  && !in_pool_r[pif.fp_ind_1];
        acc_2_s = pif.retire_flag_2 && (pif.fp_ind_2 != {PREG_W{1'b0}})
                  && !in_pool_r[pif.fp_ind_2]
                  && !(acc_1_s && (pif.fp_ind_2 == pif.fp_ind_1));
        drop_s  = (pif.retire_flag_1 && (pif.fp_ind_1 != {PREG_W{1'b0}}) && !acc_1_s)
               || (pif.retire_flag_2 && (pif.fp_ind_2 != {PREG_W{1'b0}}) && !acc_2_s);

        tail_2_s     = tail_r + idx_t'(acc_1_s);
        count_next_s = count_r - cnt_t'(grant_1_s) - cnt_t'(grant_2_s)
                               + cnt_t'(acc_1_s) + cnt_t'(acc_2_s);

        // Granted and accepted indices are always distinct, so order is irrelevant.
        pool_next_s = in_pool_r;
        pool_next_s[preg_1_s]     = pool_next_s[preg_1_s] & ~grant_1_s;
        pool_next_s[preg_2_s]     = pool_next_s[preg_2_s] & ~grant_2_s;
        pool_next_s[pif.fp_ind_1] = pool_next_s[pif.fp_ind_1] | acc_1_s;
        pool_next_s[pif.fp_ind_2] = pool_next_s[pif.fp_ind_2] | acc_2_s;
    end

    assign pif.alloc_grant_1 = grant_1_s;
    assign pif.alloc_grant_2 = grant_2_s;
    assign pif.alloc_preg_1  = preg_1_s;
    assign pif.alloc_preg_2  = preg_2_s;
    assign pif.free_count    = count_r;
    assign pif.empty         = empty_r;
    assign pif.free_err      = free_err_r;

    // Buffer storage: reset preloads the unmapped registers, frees append at tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PREG; i++) begin
                if (i < NUM_PREG - NUM_ARCH) begin
                    entries_r[i] <= idx_t'(NUM_ARCH + i);
                end else begin
                    entries_r[i] <= {PREG_W{1'b0}};
                end
            end
        end else begin
            if (acc_1_s) begin
                entries_r[tail_r] <= pif.fp_ind_1;
            end
            if (acc_2_s) begin
                entries_r[tail_2_s] <= pif.fp_ind_2;
            end
        end
    end

    // Pointers, occupancy, bitmap and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r     <= {PREG_W{1'b0}};
            tail_r     <= idx_t'(NUM_PREG - NUM_ARCH);
            count_r    <= cnt_t'(NUM_PREG - NUM_ARCH);
            empty_r    <= 1'b0;
            free_err_r <= 1'b0;
            for (int i = 0; i < NUM_PREG; i++) begin
                in_pool_r[i] <= (i >= NUM_ARCH);
            end
        end else begin
            head_r     <= head_r + idx_t'(grant_1_s) + idx_t'(grant_2_s);
            tail_r     <= tail_2_s + idx_t'(acc_2_s);
            count_r    <= count_next_s;
            empty_r    <= (count_next_s == {(PREG_W+1){1'b0}});
            free_err_r <= free_err_r | drop_s;
            in_pool_r  <= pool_next_s;
        end
    end

endmodule

// File: tb/tb_phys_free_list.sv
// Random and directed traffic for the physical-register free pool, checked
// against a queue-based model of the pool through a scoreboard.
module tb_phys_free_list;

    logic clk;
    logic rst;

    phys_free_list_if #(.IDX_W(6)) bus ();

    phys_free_list dut (
        .clk (clk),
        .rst (rst),
        .pif (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit g1;
        bit g2;
        int p1;
        int p2;
        int cnt;
        bit emp;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference pool: FIFO of free registers plus membership flags.
    int   free_q[$];
    bit   pooled [64];
    bit   m_err;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        free_q.delete();
        for (int i = 0; i < 64; i++) pooled[i] = (i >= 32);
        for (int i = 32; i < 64; i++) free_q.push_back(i);
        m_err = 1'b0;
    endtask

    // Build the expected response for this cycle, then (optionally) advance the model.
    task automatic predict(input bit r1, input bit r2, input bit f1, input int i1,
                           input bit f2, input int i2, input bit apply);
        exp_t e;
        int   n;
        bit   a1, a2;
        n     = free_q.size();
        e.cnt = n;
        e.emp = (n == 0);
        e.err = m_err;
        e.g1  = r1 && (n >= 1);
        e.g2  = r2 && (n >= (r1 ? 2 : 1));
        e.p1  = e.g1 ? free_q[0] : 0;
        e.p2  = e.g2 ? free_q[e.g1 ? 1 : 0] : 0;
        exp_q.push_back(e);
        if (apply) begin
            a1 = f1 && (i1 != 0) && !pooled[i1];
            a2 = f2 && (i2 != 0) && !pooled[i2] && !(a1 && (i1 == i2));
            if ((f1 && i1 != 0 && !a1) || (f2 && i2 != 0 && !a2)) m_err = 1'b1;
            if (e.g1) begin void'(free_q.pop_front()); pooled[e.p1] = 1'b0; end
            if (e.g2) begin void'(free_q.pop_front()); pooled[e.p2] = 1'b0; end
            if (a1) begin free_q.push_back(i1); pooled[i1] = 1'b1; end
            if (a2) begin free_q.push_back(i2); pooled[i2] = 1'b1; end
        end
    endtask

    task automatic drive(input bit r1, input bit r2, input bit f1, input int i1,
                         input bit f2, input int i2);
        bus.alloc_req_1   = r1;
        bus.alloc_req_2   = r2;
        bus.retire_flag_1 = f1;
        bus.fp_ind_1      = 6'(i1);
        bus.retire_flag_2 = f2;
        bus.fp_ind_2      = 6'(i2);
    endtask

    task automatic step(input bit r1, input bit r2, input bit f1, input int i1,
                        input bit f2, input int i2);
        drive(r1, r2, f1, i1, f2, i2);
        predict(r1, r2, f1, i1, f2, i2, 1'b1);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Assert reset away from the clock edge with both requests high.
    task automatic reset_cycle();
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
        model_reset();
        predict(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        #1;
        chk("async_rst_free_count", int'(bus.free_count), 32);
        chk("async_rst_empty", int'(bus.empty), 0);
        chk("async_rst_free_err", int'(bus.free_err), 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("grant_1", int'(bus.alloc_grant_1), int'(e.g1));
                chk("grant_2", int'(bus.alloc_grant_2), int'(e.g2));
                if (e.g1) chk("preg_1", int'(bus.alloc_preg_1), e.p1);
                if (e.g2) chk("preg_2", int'(bus.alloc_preg_2), e.p2);
                chk("free_count", int'(bus.free_count), e.cnt);
                chk("empty", int'(bus.empty), int'(e.emp));
                chk("free_err", int'(bus.free_err), int'(e.err));
            end
        end
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        reset_cycle();

        // Drain the pool in pairs: (32,33) .. (62,63).
        for (int k = 0; k < 16; k++) step(1'b1, 1'b1, 1'b0, 0, 1'b0, 0);

        // Empty pool: frees are not bypassed to same-cycle requests.
        step(1'b1, 1'b1, 1'b1, 40, 1'b1, 41);
        step(1'b1, 1'b1, 1'b0, 0, 1'b0, 0);

        // p0 is ignored silently.
        step(1'b0, 1'b0, 1'b1, 0, 1'b1, 0);

        // Single entry with both slots requesting.
        step(1'b0, 1'b0, 1'b1, 45, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 0, 1'b0, 0);

        // Duplicate frees.
        step(1'b0, 1'b0, 1'b1, 35, 1'b0, 0);
        step(1'b0, 1'b0, 1'b1, 35, 1'b0, 0);
        step(1'b0, 1'b0, 1'b1, 50, 1'b1, 50);
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0);

        // Random traffic with pointer wrap-around.
        for (int k = 0; k < 200; k++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)));
        end

        // Reset in the middle of an allocation burst.
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b1, int'($urandom_range(1, 63)), 1'b0, 0);
        reset_cycle();
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
